// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cla_nibble_serial_adder                                          |
// | Purpose  : WIDTH-bit adder that runs one 4-bit carry-lookahead slice per    |
// |            cycle, LSB nibble first, behind valid/ready handshakes.          |
// | Options  : define CLA_NIBBLE_SUB_EN to add the 'sub' port (a + ~b + 1).     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int c_cnt_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NIBBLES - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               r_carry, r_cout, r_ovf;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;
  logic [3:0]         w_an, w_bn, w_p, w_g, w_s;
  logic [4:0]         w_c;

`ifdef CLA_NIBBLE_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == c_last);

  // Operands shift right each RUN cycle, so the active nibble is always [3:0].
  assign w_an = r_a[3:0];
  assign w_bn = r_b[3:0];
  assign w_p  = w_an ^ w_bn;
  assign w_g  = w_an & w_bn;

  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s  = w_p ^ w_c[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          // Each slice result enters at the top; after NIBBLES shifts it lands in place.
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_sum   <= {w_s, r_sum[WIDTH-1:4]};
          r_carry <= w_c[4];
          r_cnt   <= r_cnt + c_one;
          if (w_last) begin
            r_cout <= w_c[4];
            r_ovf  <= w_c[3] ^ w_c[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
`default_nettype none
// Testbench for cla_nibble_serial_adder (WIDTH=16): directed table, stall,
// mid-operation reset and back-to-back scoreboard sequences.
module tb_cla_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef CLA_NIBBLE_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_NIBBLE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tcin,
                        output logic [W-1:0] rs, output logic rc, output logic ro,
                        output int lat);
    a = ta; b = tb_b; cin = tcin; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~ta; b = ~tb_b; cin = ~tcin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    tick();
  endtask

  logic [W-1:0] rs;
  logic         rc, ro;
  int           lat;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
    end

    // Stall in DONE for 10 cycles while a competing request is offered.
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("stall_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h5556);
      chk("stall_cout", 32'(cout), 32'd0);
      chk("stall_ovf", 32'(ovf), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Reset during RUN cycle 2.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, rs, rc, ro, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", 32'(rs), 32'h0007);

`ifdef CLA_NIBBLE_SUB_EN
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, rs, rc, ro, lat);
    chk("sub_5m7_sum", 32'(rs), 32'hFFFE);
    chk("sub_5m7_cout", 32'(rc), 32'd0);
    run_op(16'h8000, 16'h0001, 1'b1, rs, rc, ro, lat);
    chk("sub_8000m1_sum", 32'(rs), 32'h7FFF);
    chk("sub_8000m1_ovf", 32'(ro), 32'd1);
    run_op(16'h0007, 16'h0007, 1'b0, rs, rc, ro, lat);
    chk("sub_7m7_sum", 32'(rs), 32'h0000);
    chk("sub_7m7_cout", 32'(rc), 32'd1);
    sub = 1'b0;
`endif

    // Back-to-back operations against an arithmetic scoreboard.
    begin
      logic [W:0]   q_full[$];
      logic         q_ovf[$];
      logic [W:0]   e_full;
      logic         e_ovf;
      int           issued = 0;
      int           checked = 0;
      int           cyc = 0;
      int           last_acc = 0;
      logic [W-1:0] ra, rb;
      logic         rcin;

      out_ready = 1'b1;
      in_valid  = 1'b1;
      while (checked < 1000 && cyc < 8000) begin
        if (out_valid) begin
          if (q_full.size() == 0) begin
            chk("b2b_unexpected_result", 32'd1, 32'd0);
          end else begin
            e_full = q_full.pop_front();
            e_ovf  = q_ovf.pop_front();
            chk("b2b_sum", 32'(sum), 32'(e_full[W-1:0]));
            chk("b2b_cout", 32'(cout), 32'(e_full[W]));
            chk("b2b_ovf", 32'(ovf), 32'(e_ovf));
            checked++;
          end
        end
        if (in_ready && issued < 1000) begin
          if (issued == 0) begin
            ra = 16'hFFFF; rb = 16'hFFFF; rcin = 1'b1;
          end else begin
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
          end
          a = ra; b = rb; cin = rcin;
          e_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
          q_full.push_back(e_full);
          q_ovf.push_back((ra[W-1] == rb[W-1]) && (e_full[W-1] != ra[W-1]));
          if (issued > 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd6);
          last_acc = cyc;
          issued++;
          if (issued == 1000) in_valid = 1'b1;
        end else if (issued >= 1000) begin
          in_valid = 1'b0;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_completed", 32'(checked), 32'd1000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
